ddr_rd_pattern_checker: RTL and testbench

Synthesizable, parametrised read-back checker for the DDR2 display path. It replaces the bench-only frame counting and data assertions with an on-chip checker. It taps the line-buffer read stream, which is the same data the MIG returns after the Picoblaze preload. For every accepted beat it generates the expected word in one of four selectable patterns and compares it with the received word. It counts errors, captures the first failure, counts frames, and stops at a programmable frame limit. Results are readable by Picoblaze and visible to the testbench.

---
 rtl/ddr_chk_pkg.sv | 32 +++
 rtl/ddr_chk_pattern_gen.sv | 87 ++++++++
 rtl/ddr_rd_pattern_checker.sv | 159 +++++++++++++++
 tb/tb_ddr_rd_pattern_checker.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_chk_pkg
//  Brief    : Shared types and constants for the DDR read-back pattern checker.
//  Revision : 1.0 - initial release
// ============================================================================
package ddr_chk_pkg;

    typedef enum logic [1:0] {
        MODE_ROW  = 2'd0,
        MODE_INC  = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_WALK = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Galois right-shift feedback masks for maximal-length sequences
    localparam logic [15:0] c_lfsr_taps_16 = 16'hB400;
    localparam logic [31:0] c_lfsr_taps_32 = 32'h8020_0003;

    // Index width that never collapses to zero bits
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_chk_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_chk_pattern_gen
//  Brief    : Beat/line/address counters, LFSR and expected-word selection.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_chk_pattern_gen
    import ddr_chk_pkg::*;
#(
    parameter int          DATA_W          = 16,
    parameter int          BEATS_PER_LINE  = 64,
    parameter int          LINES_PER_FRAME = 480,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          LINE_W          = idx_w(LINES_PER_FRAME),
    parameter int          BEAT_W          = idx_w(BEATS_PER_LINE)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              reload,
    input  mode_e             mode,
    output logic [DATA_W-1:0] exp_word,
    output logic [LINE_W-1:0] line_idx,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              frame_wrap
);

    localparam logic [DATA_W-1:0] c_taps = (DATA_W == 32) ? DATA_W'(c_lfsr_taps_32)
                                                          : DATA_W'(c_lfsr_taps_16);
    localparam logic [DATA_W-1:0] c_seed = DATA_W'(LFSR_SEED);

    logic [BEAT_W-1:0] r_beat;
    logic [LINE_W-1:0] r_line;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_lfsr;

    logic              w_last_beat;
    logic              w_last_line;
    logic [DATA_W-1:0] w_lfsr_nxt;
    logic [31:0]       w_walk_sh;

    assign w_last_beat = (r_beat == BEAT_W'(BEATS_PER_LINE - 1));
    assign w_last_line = (r_line == LINE_W'(LINES_PER_FRAME - 1));
    assign frame_wrap  = advance && w_last_beat && w_last_line;
    assign w_lfsr_nxt  = {1'b0, r_lfsr[DATA_W-1:1]} ^ (r_lfsr[0] ? c_taps : '0);
    assign w_walk_sh   = 32'(r_beat) % 32'(DATA_W);

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            r_beat <= '0;
            r_line <= '0;
            r_addr <= '0;
            r_lfsr <= c_seed;
        end else if (advance) begin
            if (w_last_beat) begin
                r_beat <= '0;
                r_line <= w_last_line ? '0 : r_line + LINE_W'(1);
            end else begin
                r_beat <= r_beat + BEAT_W'(1);
            end
            // Address and LFSR restart so every frame carries the same pattern
            if (frame_wrap) begin
                r_addr <= '0;
                r_lfsr <= c_seed;
            end else begin
                r_addr <= r_addr + DATA_W'(1);
                r_lfsr <= w_lfsr_nxt;
            end
        end
    end

    always_comb begin
        exp_word = '0;
        case (mode)
            MODE_ROW:  exp_word = DATA_W'(r_line);
            MODE_INC:  exp_word = r_addr;
            MODE_LFSR: exp_word = r_lfsr;
            MODE_WALK: exp_word = DATA_W'(1) << w_walk_sh;
            default:   exp_word = '0;
        endcase
    end

    assign line_idx = r_line;
    assign beat_idx = r_beat;

endmodule
`default_nettype wire

// File: rtl/ddr_rd_pattern_checker.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_rd_pattern_checker
//  Brief    : Read-back checker: run control, comparator, error count, first-error capture.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_rd_pattern_checker
    import ddr_chk_pkg::*;
#(
    parameter int          DATA_W          = 16,
    parameter int          BEATS_PER_LINE  = 64,
    parameter int          LINES_PER_FRAME = 480,
    parameter int          FRAME_CNT_W     = 8,
    parameter int          ERR_CNT_W       = 16,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
)(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                abort,
    input  logic [1:0]                          mode,
    input  logic [FRAME_CNT_W-1:0]              frame_limit,
    input  logic                                rd_valid,
    input  logic [DATA_W-1:0]                   rd_data,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [FRAME_CNT_W-1:0]              frame_cnt,
    output logic [ERR_CNT_W-1:0]                err_cnt,
    output logic                                first_err_vld,
    output logic [idx_w(LINES_PER_FRAME)-1:0]   first_err_line,
    output logic [idx_w(BEATS_PER_LINE)-1:0]    first_err_beat,
    output logic [DATA_W-1:0]                   first_err_data,
    output logic [DATA_W-1:0]                   first_err_exp
);

    localparam int LINE_W = idx_w(LINES_PER_FRAME);
    localparam int BEAT_W = idx_w(BEATS_PER_LINE);

    state_e                r_state;
    state_e                w_state_nxt;
    mode_e                 r_mode;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [ERR_CNT_W-1:0]   r_err_cnt;
    logic                   r_first_vld;
    logic [LINE_W-1:0]      r_first_line;
    logic [BEAT_W-1:0]      r_first_beat;
    logic [DATA_W-1:0]      r_first_data;
    logic [DATA_W-1:0]      r_first_exp;

    logic              w_start;
    logic              w_clear;
    logic              w_accept;
    logic              w_mismatch;
    logic              w_frame_wrap;
    logic              w_final_frame;
    logic [DATA_W-1:0] w_exp;
    logic [LINE_W-1:0] w_line;
    logic [BEAT_W-1:0] w_beat;

    // abort dominates start; start only re-arms from outside RUN
    assign w_start       = start && !abort;
    assign w_clear       = w_start && (r_state != RUN);
    assign w_accept      = (r_state == RUN) && rd_valid && !abort;
    assign w_mismatch    = w_accept && (rd_data != w_exp);
    assign w_final_frame = (frame_limit != '0) &&
                           ((r_frame_cnt + FRAME_CNT_W'(1)) == frame_limit);

    ddr_chk_pattern_gen #(
        .DATA_W          (DATA_W),
        .BEATS_PER_LINE  (BEATS_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME),
        .LFSR_SEED       (LFSR_SEED),
        .LINE_W          (LINE_W),
        .BEAT_W          (BEAT_W)
    ) u_pattern_gen (
        .clk        (clk),
        .rst        (rst),
        .advance    (w_accept),
        .reload     (w_clear),
        .mode       (r_mode),
        .exp_word   (w_exp),
        .line_idx   (w_line),
        .beat_idx   (w_beat),
        .frame_wrap (w_frame_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mode  <= MODE_ROW;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_mode <= mode_e'(mode);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) w_state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (abort)                               w_state_nxt = IDLE;
                else if (w_frame_wrap && w_final_frame)  w_state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (w_start) w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
        pass = done && (r_err_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_frame_cnt  <= '0;
            r_err_cnt    <= '0;
            r_first_vld  <= 1'b0;
            r_first_line <= '0;
            r_first_beat <= '0;
            r_first_data <= '0;
            r_first_exp  <= '0;
        end else begin
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
            if (w_mismatch) begin
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
                if (!r_first_vld) begin
                    r_first_vld  <= 1'b1;
                    r_first_line <= w_line;
                    r_first_beat <= w_beat;
                    r_first_data <= rd_data;
                    r_first_exp  <= w_exp;
                end
            end
        end
    end

    assign frame_cnt      = r_frame_cnt;
    assign err_cnt        = r_err_cnt;
    assign first_err_vld  = r_first_vld;
    assign first_err_line = r_first_line;
    assign first_err_beat = r_first_beat;
    assign first_err_data = r_first_data;
    assign first_err_exp  = r_first_exp;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_pattern_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_rd_pattern_checker
//  Brief    : Self-checking bench for the DDR read-back pattern checker.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ddr_rd_pattern_checker;

    localparam int B  = 4;
    localparam int L  = 3;
    localparam int FB = B * L;

    logic        clk = 1'b0;
    logic        rst, start, abort, rd_valid;
    logic [1:0]  mode;
    logic [7:0]  frame_limit;
    logic [15:0] rd_data;

    logic        busy, done, pass, fvld;
    logic [7:0]  frame_cnt;
    logic [15:0] err_cnt, fdata, fexp;
    logic [1:0]  fline, fbeat;

    logic        s_busy, s_done, s_pass, s_fvld;
    logic [7:0]  s_frame_cnt;
    logic [1:0]  s_err_cnt, s_fline, s_fbeat;
    logic [15:0] s_fdata, s_fexp;

    always #5 clk = ~clk;

    ddr_rd_pattern_checker #(
        .DATA_W(16), .BEATS_PER_LINE(B), .LINES_PER_FRAME(L),
        .FRAME_CNT_W(8), .ERR_CNT_W(16), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .frame_limit(frame_limit), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .pass(pass), .frame_cnt(frame_cnt),
        .err_cnt(err_cnt), .first_err_vld(fvld), .first_err_line(fline),
        .first_err_beat(fbeat), .first_err_data(fdata), .first_err_exp(fexp)
    );

    ddr_rd_pattern_checker #(
        .DATA_W(16), .BEATS_PER_LINE(B), .LINES_PER_FRAME(L),
        .FRAME_CNT_W(8), .ERR_CNT_W(2), .LFSR_SEED(16'hACE1)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .frame_limit(frame_limit), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(s_busy), .done(s_done), .pass(s_pass), .frame_cnt(s_frame_cnt),
        .err_cnt(s_err_cnt), .first_err_vld(s_fvld), .first_err_line(s_fline),
        .first_err_beat(s_fbeat), .first_err_data(s_fdata), .first_err_exp(s_fexp)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: state 0=idle 1=run 2=done; m_n counts accepted beats since start
    int          m_state, m_mode, m_n, m_frames, m_err, m_fl, m_fb;
    bit          m_fv;
    logic [15:0] m_fd, m_fe;

    typedef struct {
        logic [15:0] data;
        int          exp_err;
        int          exp_frames;
        bit          exp_done;
    } vec_t;
    vec_t vecs [24];

    function automatic logic [15:0] lfsr_at(input int k);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        return s;
    endfunction

    function automatic logic [15:0] model_exp(input int md, input int n);
        int k;
        k = n % FB;
        case (md)
            0:       return 16'(k / B);
            1:       return 16'(k);
            2:       return lfsr_at(k);
            default: return 16'(1) << ((k % B) % 16);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_n = 0; m_frames = 0; m_err = 0; m_fv = 0;
        m_fl = 0; m_fb = 0; m_fd = '0; m_fe = '0;
    endtask

    task automatic model_edge(input bit s, input bit a, input bit v, input logic [15:0] d);
        logic [15:0] e;
        if (m_state == 1) begin
            if (a) m_state = 0;
            else if (v) begin
                e = model_exp(m_mode, m_n);
                if (d !== e) begin
                    m_err++;
                    if (!m_fv) begin
                        m_fv = 1; m_fl = (m_n % FB) / B; m_fb = m_n % B; m_fd = d; m_fe = e;
                    end
                end
                m_n++;
                if (m_n % FB == 0) begin
                    m_frames = (m_frames + 1) % 256;
                    if (frame_limit != 0 && m_frames == int'(frame_limit)) m_state = 2;
                end
            end
        end else if (s && !a) begin
            m_state = 1;
            m_mode  = int'(mode);
            model_clear();
        end
    endtask

    task automatic check_all();
        chk("busy", busy, m_state == 1);
        chk("done", done, m_state == 2);
        chk("pass", pass, (m_state == 2) && (m_err == 0));
        chk("frame_cnt", frame_cnt, m_frames);
        chk("err_cnt", err_cnt, (m_err > 65535) ? 65535 : m_err);
        chk("first_vld", fvld, m_fv);
        chk("first_line", fline, m_fl);
        chk("first_beat", fbeat, m_fb);
        chk("first_data", fdata, m_fd);
        chk("first_exp", fexp, m_fe);
        chk("sat_err_cnt", s_err_cnt, (m_err > 3) ? 3 : m_err);
        chk("sat_status", {s_busy, s_done, s_pass, s_fvld, s_frame_cnt},
            {m_state == 1, m_state == 2, (m_state == 2) && (m_err == 0), m_fv, 8'(m_frames)});
        chk("sat_first", {s_fline, s_fbeat, s_fdata, s_fexp}, {2'(m_fl), 2'(m_fb), m_fd, m_fe});
    endtask

    task automatic cycle(input bit s, input bit a, input bit v, input logic [15:0] d);
        start = s; abort = a; rd_valid = v; rd_data = d;
        model_edge(s, a, v, d);
        @(posedge clk); #1;
        start = 0; abort = 0; rd_valid = 0;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1; start = 0; abort = 0; rd_valid = 0;
        m_state = 0; m_mode = 0; model_clear();
        @(posedge clk); #1;
        rst = 0;
        check_all();
    endtask

    task automatic arm(input int md, input int lim);
        mode = 2'(md); frame_limit = 8'(lim);
        cycle(1, 0, 0, '0);
    endtask

    initial begin
        rst = 0; start = 0; abort = 0; rd_valid = 0; mode = 0; frame_limit = 0; rd_data = 0;
        for (int i = 0; i < 24; i++) begin
            vecs[i].data       = 16'((i % 12) / 4);
            vecs[i].exp_err    = 0;
            vecs[i].exp_frames = (i + 1) / 12;
            vecs[i].exp_done   = (i == 23);
        end
        @(posedge clk); #1;
        do_reset();

        // Clean row-index run over two frames
        arm(0, 2);
        for (int i = 0; i < 24; i++) begin
            cycle(0, 0, 1, vecs[i].data);
            chk("t1_err", err_cnt, vecs[i].exp_err);
            chk("t1_frames", frame_cnt, vecs[i].exp_frames);
            chk("t1_done", done, vecs[i].exp_done);
            chk("t1_pass", pass, vecs[i].exp_done);
        end

        // Single injected error in incrementing mode
        arm(1, 1);
        for (int i = 0; i < 12; i++) cycle(0, 0, 1, (i == 6) ? 16'h0000 : 16'(i));
        chk("t2_err", err_cnt, 1);
        chk("t2_line", fline, 1);
        chk("t2_beat", fbeat, 2);
        chk("t2_exp", fexp, 16'h0006);
        chk("t2_data", fdata, 16'h0000);
        chk("t2_pass", {done, pass}, 2'b10);

        // LFSR with two corrupted beats; frame 2 must restart at the seed
        arm(2, 2);
        for (int i = 0; i < 24; i++) begin
            if (i == 12)               cycle(0, 0, 1, 16'hACE1);
            else if (i == 5 || i == 9) cycle(0, 0, 1, ~lfsr_at(i % 12));
            else                       cycle(0, 0, 1, lfsr_at(i % 12));
            if (i == 12) chk("t3_restart", err_cnt, 2);
        end
        chk("t3_err", err_cnt, 2);
        chk("t3_first", {fline, fbeat}, {2'd1, 2'd1});
        chk("t3_exp", fexp, 16'h5670 ^ 16'h0000 ^ lfsr_at(5) ^ 16'h5670);

        // Saturation of the narrow error counter, walking-one mode
        arm(3, 1);
        for (int i = 0; i < 12; i++) cycle(0, 0, 1, 16'h0000);
        cycle(0, 0, 1, 16'h0000);
        chk("t4_sat", s_err_cnt, 2'd3);
        chk("t4_wide", err_cnt, 12);
        chk("t4_first", {s_fline, s_fbeat, s_fexp, s_fdata}, {2'd0, 2'd0, 16'h0001, 16'h0000});

        // Abort, re-arm, start ignored in RUN, start+abort together
        arm(0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 16'hFFFF);
        cycle(0, 1, 0, '0);
        chk("t5_busy", busy, 0);
        chk("t5_err_held", err_cnt, 7);
        chk("t5_frames_held", frame_cnt, 0);
        cycle(0, 0, 1, 16'hFFFF);
        chk("t5_idle_ignore", err_cnt, 7);
        arm(0, 0);
        chk("t5_cleared", {err_cnt, 7'(0), fvld}, 24'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 16'hFFFF);
        cycle(1, 0, 0, '0);
        chk("t5_start_in_run", err_cnt, 3);
        cycle(1, 1, 0, '0);
        chk("t5_both_run", busy, 0);
        cycle(1, 1, 0, '0);
        chk("t5_both_idle", busy, 0);

        // Reset in the middle of a run
        arm(1, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 16'(i));
        do_reset();
        chk("t6_zero", {busy, done, pass, frame_cnt, err_cnt, fvld}, '0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 16'hFFFF);
        chk("t6_ignored", err_cnt, 0);

        // Randomized traffic against the model
        arm(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2)       do_reset();
            else if (r < 7)  arm(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else if (r < 9)  cycle(0, 1, bit'($urandom_range(0, 1)), 16'($urandom));
            else if (r < 10) cycle(1, 1, 0, '0);
            else if (r < 16) cycle(0, 0, 0, 16'($urandom));
            else if (r < 82) cycle(0, 0, 1, model_exp(m_mode, m_n));
            else             cycle(0, 0, 1, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
